// File: rtl/writeonly_registers.sv
// Processor-written register bank with byte/half/word store merging and a per-register
// valid/ack/overrun handshake toward a peripheral. Define WRITEONLY_REGS_READBACK_EN to allow loads.
module writeonly_registers #(
  parameter int          ADDR_COUNT  = 1,
  parameter int          ADDR_START  = 0,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int          ADDR_W      = 32,
  localparam int         WORD_W      = 32,
  localparam int         MEM_COUNT_W = 3,
  localparam int         MEM_CODE_W  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            i_req_addr,
  input  logic [MEM_COUNT_W-1:0]       i_req_count,
  input  logic                         i_req_wr_en,
  input  logic [WORD_W-1:0]            i_req_wr_data,
  output logic [WORD_W-1:0]            o_res_rd_data,
  output logic [MEM_CODE_W-1:0]        o_res_code,
  output logic [ADDR_COUNT*WORD_W-1:0] o_registers,
  output logic [ADDR_COUNT-1:0]        o_reg_valid,
  input  logic [ADDR_COUNT-1:0]        i_reg_ack,
  output logic [ADDR_COUNT-1:0]        o_reg_overrun
);

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 3'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 3'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 3'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID    = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 2'd3;

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] START_IDX = IDX_W'(ADDR_START);
  localparam logic [IDX_W:0]   END_IDX   = (IDX_W+1)'(ADDR_START + ADDR_COUNT);

  logic [ADDR_COUNT*WORD_W-1:0] regs_reg, regs_next;
  logic [ADDR_COUNT-1:0]        valid_reg, valid_next;
  logic [ADDR_COUNT-1:0]        overrun_reg, overrun_next;
  logic [WORD_W-1:0]            rd_data_reg, rd_data_next;
  logic [MEM_CODE_W-1:0]        code_reg, code_next;

  logic [IDX_W-1:0]      idx, local_idx;
  logic [1:0]            off;
  logic                  in_range, misaligned, known_count, resp_en, store;
  logic [WORD_W-1:0]     wr_mask, wr_lanes;
  logic [ADDR_COUNT-1:0] sel, store_hit, ack_hit;

  assign idx         = i_req_addr[ADDR_W-1:2];
  assign off         = i_req_addr[1:0];
  assign local_idx   = idx - START_IDX;
  assign in_range    = (idx >= START_IDX) && ({1'b0, idx} < END_IDX);
  assign misaligned  = ((i_req_count == MEM_COUNT_HALF) && off[0]) ||
                       ((i_req_count == MEM_COUNT_WORD) && (off != 2'd0));
  assign known_count = (i_req_count == MEM_COUNT_BYTE) || (i_req_count == MEM_COUNT_HALF) ||
                       (i_req_count == MEM_COUNT_WORD);
  assign resp_en     = (i_req_count != MEM_COUNT_NONE);

  // Store data is replicated across lanes; the mask picks which lanes land.
  always_comb begin
    wr_mask  = '0;
    wr_lanes = '0;
    case (i_req_count)
      MEM_COUNT_BYTE: begin
        wr_mask  = 32'h0000_00FF << {off, 3'b000};
        wr_lanes = {4{i_req_wr_data[7:0]}};
      end
      MEM_COUNT_HALF: begin
        wr_mask  = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_lanes = {2{i_req_wr_data[15:0]}};
      end
      MEM_COUNT_WORD: begin
        wr_mask  = 32'hFFFF_FFFF;
        wr_lanes = i_req_wr_data;
      end
      default: begin
        wr_mask  = '0;
        wr_lanes = '0;
      end
    endcase
  end

`ifdef WRITEONLY_REGS_READBACK_EN
  logic [WORD_W-1:0] sel_word, sel_shifted;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < ADDR_COUNT; i++) begin
      if (sel[i]) sel_word = regs_reg[i*WORD_W +: WORD_W];
    end
  end

  assign sel_shifted = sel_word >> {off, 3'b000};
`endif

  always_comb begin
    code_next    = MEM_CODE_INVALID;
    rd_data_next = '0;
    store        = 1'b0;
    if (misaligned) begin
      code_next = MEM_CODE_MISALIGNED;
    end else if (!in_range || !known_count) begin
      code_next = MEM_CODE_INVALID;
    end else if (i_req_wr_en) begin
      code_next = MEM_CODE_WRITE;
      store     = 1'b1;
    end else begin
`ifdef WRITEONLY_REGS_READBACK_EN
      code_next = MEM_CODE_READ;
      case (i_req_count)
        MEM_COUNT_BYTE: rd_data_next = {24'd0, sel_shifted[7:0]};
        MEM_COUNT_HALF: rd_data_next = {16'd0, sel_shifted[15:0]};
        default:        rd_data_next = sel_word;
      endcase
`else
      code_next = MEM_CODE_INVALID;
`endif
    end
  end

  // An ack consumes the pending value, so it also retires any overrun on that register.
  generate
    for (genvar gi = 0; gi < ADDR_COUNT; gi++) begin : g_reg
      assign sel[gi]       = in_range && (local_idx == IDX_W'(gi));
      assign store_hit[gi] = store && sel[gi];
      assign ack_hit[gi]   = i_reg_ack[gi] && valid_reg[gi];
      assign regs_next[gi*WORD_W +: WORD_W] = store_hit[gi]
          ? ((regs_reg[gi*WORD_W +: WORD_W] & ~wr_mask) | (wr_lanes & wr_mask))
          : regs_reg[gi*WORD_W +: WORD_W];
      assign valid_next[gi]   = store_hit[gi] | (valid_reg[gi] & ~ack_hit[gi]);
      assign overrun_next[gi] = (store_hit[gi] & valid_reg[gi] & ~i_reg_ack[gi]) |
                                (overrun_reg[gi] & ~ack_hit[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_reg    <= {ADDR_COUNT{RESET_VALUE}};
      valid_reg   <= '0;
      overrun_reg <= '0;
      rd_data_reg <= '0;
      code_reg    <= MEM_CODE_INVALID;
    end else begin
      regs_reg    <= regs_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      if (resp_en) begin
        rd_data_reg <= rd_data_next;
        code_reg    <= code_next;
      end
    end
  end

  assign o_registers   = regs_reg;
  assign o_reg_valid   = valid_reg;
  assign o_reg_overrun = overrun_reg;
  assign o_res_rd_data = rd_data_reg;
  assign o_res_code    = code_reg;

endmodule
